// File: rtl/formula_sweep_driver.sv
// Exhaustive sweep driver for a combinational formula: walks every input assignment in order,
// counts satisfying ones and streams them out through a small first-word-fall-through FIFO.
module formula_sweep_driver #(
  parameter int NUM_VARS   = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = NUM_VARS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [NUM_VARS-1:0] vec_out,
  input  logic                f_in,
  output logic [CNT_W-1:0]    sat_count,
  output logic                sol_valid,
  input  logic                sol_ready,
  output logic [NUM_VARS-1:0] sol_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [NUM_VARS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                fifo_full, fifo_empty;
  logic                push, pop, stall, advance, clear;
  logic                last_vec;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign sol_valid  = ~fifo_empty;
  assign sol_data   = sol_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign pop        = sol_valid & sol_ready;
  assign last_vec   = &vec_out;
  assign busy       = (state == SWEEP);
  assign done       = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and sweep control.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    advance    = 1'b0;
    push       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = SWEEP;
          clear      = 1'b1;
        end else begin
          next_state = state;
        end
      end
      SWEEP: begin
        // A full FIFO can still accept a push when the consumer frees a slot this cycle.
        stall = f_in & fifo_full & ~pop;
        if (!stall) begin
          advance = 1'b1;
          push    = f_in;
          if (last_vec) begin
            next_state = DONE;
          end else begin
            next_state = SWEEP;
          end
        end else begin
          next_state = SWEEP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Sweep vector, solution counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out   <= '0;
      sat_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (clear) begin
        vec_out   <= '0;
        sat_count <= '0;
      end else if (advance) begin
        if (push) begin
          sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (!last_vec) begin
          vec_out <= vec_out + {{(NUM_VARS-1){1'b0}}, 1'b1};
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Solution storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= vec_out;
    end
  end

endmodule

// File: tb/tb_formula_sweep_driver.sv
// Scoreboard bench for formula_sweep_driver with a 5-bit mirror-equality formula.
// Expected solutions are queued when a sweep starts; a monitor pops and compares each accepted beat.
module tb_formula_sweep_driver;

  localparam int NV = 10;
  localparam int CW = NV + 1;

  logic          clk = 1'b0;
  logic          rst, start, sol_ready;
  logic          busy, done, sol_valid, f_in;
  logic [NV-1:0] vec_out, sol_data;
  logic [CW-1:0] sat_count;

  int n_checks = 0;
  int n_pass   = 0;
  int beats    = 0;
  int busy_cnt = 0;
  int rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 manual
  int exp_q[$];

  always #5 clk = ~clk;

  // Formula under test: upper five inputs mirror the lower five.
  assign f_in = (vec_out[4:0] == vec_out[9:5]);

  formula_sweep_driver #(.NUM_VARS(NV), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .vec_out(vec_out), .f_in(f_in), .sat_count(sat_count),
    .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_data(sol_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Consumer ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: sol_ready = 1'b0;
      1: sol_ready = 1'b1;
      2: sol_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: inputs are stable from posedge+1 to the next posedge, so negedge sees the handshake.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!rst && sol_valid && sol_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", int'(sol_data), -1);
      else chk("sol_data", int'(sol_data), exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: all assignments whose two 5-bit halves are equal, ascending.
  task automatic start_sweep();
    start = 1'b1;
    for (int v = 0; v < (1 << NV); v++)
      if ((v % 32) == (v / 32)) exp_q.push_back(v);
    busy_cnt = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_vec(input int target);
    int n = 0;
    while (int'(vec_out) != target && n < 5000) begin step(); n++; end
    if (n >= 5000) chk("wait_vec_timeout", int'(vec_out), target);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin step(); n++; end
    if (n >= 5000) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 1;
    while (sol_valid && n < 100) begin step(); n++; end
    step();
    chk("drain_empty", int'(sol_valid), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vec", int'(vec_out), 0);
    chk("rst_cnt", int'(sat_count), 0);
    chk("rst_valid", int'(sol_valid), 0);
    chk("rst_data", int'(sol_data), 0);
    rst = 1'b0;
    step();
  endtask

  task automatic full_sweep(input bit pulse_mid);
    rdy_mode = 1;
    step();
    start_sweep();
    chk("sweep_busy", int'(busy), 1);
    if (pulse_mid) begin
      wait_vec(500);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done();
    chk("sweep_busy_cycles", busy_cnt, 1024);
    chk("sweep_done", int'(done), 1);
    chk("sweep_count", int'(sat_count), 32);
    chk("sweep_last_vec", int'(vec_out), 1023);
    drain();
  endtask

  int b0;

  initial begin
    rst = 1'b1; start = 1'b0; sol_ready = 1'b0;
    step();
    do_reset();

    // Plain sweep, then a sweep with an ignored mid-sweep start.
    full_sweep(1'b0);
    full_sweep(1'b1);

    // Consumer stalled: FIFO fills and the sweep holds at 132.
    rdy_mode = 3;
    sol_ready = 1'b0;
    start_sweep();
    wait_vec(132);
    repeat (3) step();
    chk("stall_vec", int'(vec_out), 132);
    chk("stall_cnt", int'(sat_count), 4);
    chk("stall_busy", int'(busy), 1);
    chk("stall_valid", int'(sol_valid), 1);
    chk("stall_head", int'(sol_data), 0);
    // One-cycle ready pulse: simultaneous pop of 0 and push of 132.
    sol_ready = 1'b1;
    step();
    sol_ready = 1'b0;
    chk("pulse_cnt", int'(sat_count), 5);
    chk("pulse_vec", int'(vec_out), 133);
    chk("pulse_head", int'(sol_data), 33);
    rdy_mode = 1;
    wait_done();
    chk("stall_final_cnt", int'(sat_count), 32);
    drain();

    // Reset mid-sweep, then a fresh sweep.
    start_sweep();
    wait_vec(300);
    do_reset();
    full_sweep(1'b0);

    // Restart from DONE with a stalled consumer keeps FIFO contents.
    b0 = beats;
    rdy_mode = 2;
    start_sweep();
    wait_done();
    chk("rand_done_cnt", int'(sat_count), 32);
    rdy_mode = 3;
    sol_ready = 1'b0;
    start_sweep();
    chk("restart_cnt", int'(sat_count), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    rdy_mode = 2;
    wait_done();
    chk("restart_final_cnt", int'(sat_count), 32);
    drain();
    chk("restart_total_beats", beats - b0, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
